// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor_1_bit.sv
// Single-bit full subtractor cell, gate-level mirror of the adder's full-adder cell.
module full_subtractor_1_bit (
  output logic diff,
  output logic borrow_out,
  input  logic a,
  input  logic b,
  input  logic borrow_in
);

  logic a_xor_b;
  logic a_n;
  logic xor_n;
  logic brw_gen;
  logic brw_prop;

  // A borrow is generated when a=0,b=1 and propagated when a==b.
  xor g_x0 (a_xor_b, a, b);
  xor g_x1 (diff, a_xor_b, borrow_in);
  not g_n0 (a_n, a);
  not g_n1 (xor_n, a_xor_b);
  and g_a0 (brw_gen, a_n, b);
  and g_a1 (brw_prop, xor_n, borrow_in);
  or  g_o0 (borrow_out, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock LSB first,
// result and borrow held in registers and flagged by a one-cycle done strobe.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             b_out_q, b_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_diff;
  logic             bit_borrow;

  full_subtractor_1_bit u_cell (
    .diff       (bit_diff),
    .borrow_out (bit_borrow),
    .a          (a_sh_q[0]),
    .b          (b_sh_q[0]),
    .borrow_in  (brw_q)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    b_out_d = b_out_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = b_in;
          d_sh_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = {bit_diff, d_sh_q[WIDTH-1:1]};
        brw_d  = bit_borrow;
        cnt_d  = cnt_q + CNT_W'(1);
        // The last bit lands in diff directly, so the result is complete on entry to DONE.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          diff_d  = {bit_diff, d_sh_q[WIDTH-1:1]};
          b_out_d = bit_borrow;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      b_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      b_out_q <= b_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level reference model plus directed checks.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an operation occupies WIDTH cycles, then the result appears with done.
  int               m_remaining = 0;
  logic [WIDTH:0]   m_pending   = '0;
  logic             m_done      = 1'b0;
  logic [WIDTH-1:0] m_diff      = '0;
  logic             m_bout      = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remaining = 0;
      m_done      = 1'b0;
      m_diff      = '0;
      m_bout      = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_remaining > 0) begin
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_done = 1'b1;
          {m_bout, m_diff} = m_pending;
        end
      end else if (start) begin
        m_remaining = WIDTH;
        m_pending   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(b_in);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_busy",  32'(busy),  32'(m_remaining > 0));
      checkOutput("model_done",  32'(done),  32'(m_done));
      checkOutput("model_diff",  32'(diff),  32'(m_diff));
      checkOutput("model_b_out", 32'(b_out), 32'(m_bout));
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic bin);
    @(posedge clk);
    #2;
    a     = av;
    b     = bv;
    b_in  = bin;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL done_timeout: got no done within 20 cycles, expected done");
  endtask

  int lat;
  int busy_cnt;
  int done_cnt;
  int order[512];
  logic [8:0] v;
  logic [WIDTH:0] exp5;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_done",  32'(done),  32'd0);
    checkOutput("reset_diff",  32'(diff),  32'd0);
    checkOutput("reset_b_out", 32'(b_out), 32'd0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // 9 - 3 = 6
    applyStimulus(4'd9, 4'd3, 1'b0);
    waitDone(lat, busy_cnt);
    checkOutput("op1_latency", 32'(lat), 32'd5);
    checkOutput("op1_busy_cycles", 32'(busy_cnt), 32'd4);
    checkOutput("op1_diff", 32'(diff), 32'h6);
    checkOutput("op1_b_out", 32'(b_out), 32'd0);

    // 3 - 9 wraps to A with borrow
    applyStimulus(4'd3, 4'd9, 1'b0);
    waitDone(lat, busy_cnt);
    checkOutput("op2_diff", 32'(diff), 32'hA);
    checkOutput("op2_b_out", 32'(b_out), 32'd1);

    // reset two bits into an operation discards it
    applyStimulus(4'd9, 4'd3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy",  32'(busy),  32'd0);
    checkOutput("midrst_done",  32'(done),  32'd0);
    checkOutput("midrst_diff",  32'(diff),  32'd0);
    checkOutput("midrst_b_out", 32'(b_out), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(4'd5, 4'd2, 1'b0);
    waitDone(lat, busy_cnt);
    checkOutput("post_rst_diff", 32'(diff), 32'h3);
    checkOutput("post_rst_b_out", 32'(b_out), 32'd0);

    // 0 - 0 - 1 = F with borrow
    applyStimulus(4'd0, 4'd0, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("op3_diff", 32'(diff), 32'hF);
    checkOutput("op3_b_out", 32'(b_out), 32'd1);

    // start held during DONE begins the next operation with no idle cycle
    a     = 4'd15;
    b     = 4'd15;
    b_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_hold_diff", 32'(diff), 32'hF);
    checkOutput("b2b_hold_b_out", 32'(b_out), 32'd1);
    waitDone(lat, busy_cnt);
    checkOutput("b2b_latency", 32'(lat), 32'd4);
    checkOutput("b2b_diff", 32'(diff), 32'h0);
    checkOutput("b2b_b_out", 32'(b_out), 32'd0);

    // a second start during SHIFT is ignored
    applyStimulus(4'd7, 4'd2, 1'b0);
    @(posedge clk);
    #2;
    a     = 4'd1;
    b     = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("ignore_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ignore_diff", 32'(diff), 32'h5);
    checkOutput("ignore_b_out", 32'(b_out), 32'd0);

    // every operand/borrow combination in shuffled order
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      v = 9'(order[i]);
      applyStimulus(v[8:5], v[4:1], v[0]);
      waitDone(lat, busy_cnt);
      exp5 = {1'b0, v[8:5]} - {1'b0, v[4:1]} - 5'(v[0]);
      checkOutput("sweep_result", 32'({b_out, diff}), 32'(exp5));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
